// File: rtl/ifu_predecode_queue_pkg.sv
// ifu_pkg: shared constants and the predecode record for the IFU predecode queue.
//   OP_BRANCH / OP_JAL / OP_JALR : RV control-transfer major opcodes (instr[6:0])
//   pd_t                         : per-word predecode record. Fields are sized for the
//                                  widest XLEN; narrower instances use the low XLEN bits.
package ifu_pkg;
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                bxx;
    logic                jal;
    logic                jalr;
    logic [XLEN_MAX-1:0] offset;
    logic                pred_taken;
    logic [XLEN_MAX-1:0] target;
  } pd_t;
endpackage

// File: rtl/ifu_predecode_queue_if.sv
// Handshake bundle between fetch (producer), the predecode queue and the consumer.
//   flush                    : drop every queued word
//   in_valid/in_ready        : push handshake, in_instr/in_pc the offered word
//   out_valid/out_ready      : pop handshake, out_* the head entry and its predecode
//   count                    : occupied entries
// master = environment side, slave = the queue.
interface ifu_predecode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [XLEN-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [XLEN-1:0]        out_pc;
  logic                   out_bxx;
  logic                   out_jal;
  logic                   out_jalr;
  logic [XLEN-1:0]        out_offset;
  logic                   out_pred_taken;
  logic [XLEN-1:0]        out_target;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_bxx, out_jal, out_jalr,
           out_offset, out_pred_taken, out_target, count
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_bxx, out_jal, out_jalr,
           out_offset, out_pred_taken, out_target, count
  );
endinterface

// File: rtl/ifu_predecode_queue_slot.sv
// ifu_predecode_slot: combinational predecode of one fetched word.
//   i_instr : 32-bit instruction
//   i_pc    : PC of i_instr
//   o_pd    : control-transfer flags, sign-extended offset, static prediction, target
module ifu_predecode_slot
  import ifu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit STATIC_PRED = 1'b1
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output pd_t             o_pd
);
  logic [6:0]      w_op;
  logic            w_std;
  logic            w_bxx, w_jal, w_jalr;
  logic [XLEN-1:0] w_off;

  assign w_op   = i_instr[6:0];
  // compressed encodings (instr[1:0] != 11) never decode as control transfers
  assign w_std  = (i_instr[1:0] == 2'b11);
  assign w_bxx  = w_std & (w_op == OP_BRANCH);
  assign w_jal  = w_std & (w_op == OP_JAL);
  assign w_jalr = w_std & (w_op == OP_JALR);

  always_comb begin
    w_off = '0;
    if (w_bxx)
      w_off = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
               i_instr[11:8], 1'b0};
    else if (w_jal)
      w_off = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
               i_instr[30:21], 1'b0};
    else if (w_jalr)
      w_off = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  end

  always_comb begin
    o_pd                    = '0;
    o_pd.bxx                = w_bxx;
    o_pd.jal                = w_jal;
    o_pd.jalr               = w_jalr;
    o_pd.offset[XLEN-1:0]   = w_off;
    // backward branches predicted taken when static prediction is enabled
    o_pd.pred_taken         = w_jal | (w_bxx & STATIC_PRED & w_off[XLEN-1]);
    // jalr target depends on a register, so no target is predicted for it
    if (w_bxx | w_jal)
      o_pd.target[XLEN-1:0] = i_pc + w_off;
  end
endmodule

// File: rtl/ifu_predecode_queue.sv
// ifu_predecode_queue: DEPTH-entry in-order FIFO of fetched words, each stored with
// its predecode record computed on the push side.
//   clk, rst : clock, synchronous active-high reset
//   q        : slave side of ifu_predecode_queue_if (push, pop, flush, count, head fields)
// Full blocks push even when a pop happens the same cycle; no push-to-pop bypass.
module ifu_predecode_queue
  import ifu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter bit STATIC_PRED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ifu_predecode_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  pd_t             r_pd    [DEPTH];

  pd_t  w_pd, w_head;
  logic w_full, w_empty, w_push, w_pop;

  ifu_predecode_slot #(.XLEN(XLEN), .STATIC_PRED(STATIC_PRED)) u_slot (
    .i_instr (q.in_instr),
    .i_pc    (q.in_pc),
    .o_pd    (w_pd)
  );

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = q.in_valid  & ~w_full;
  assign w_pop   = q.out_ready & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Only slot 0 is cleared: after reset the head pointer sits there, so out_* read 0
  // until the first push without resetting the whole array.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr[0] <= '0;
      r_pc[0]    <= '0;
      r_pd[0]    <= '0;
    end else if (w_push && !q.flush) begin
      r_instr[r_wr] <= q.in_instr;
      r_pc[r_wr]    <= q.in_pc;
      r_pd[r_wr]    <= w_pd;
    end
  end

  assign w_head           = r_pd[r_rd];
  assign q.in_ready       = ~w_full;
  assign q.out_valid      = ~w_empty;
  assign q.count          = r_count;
  assign q.out_instr      = r_instr[r_rd];
  assign q.out_pc         = r_pc[r_rd];
  assign q.out_bxx        = w_head.bxx;
  assign q.out_jal        = w_head.jal;
  assign q.out_jalr       = w_head.jalr;
  assign q.out_offset     = w_head.offset[XLEN-1:0];
  assign q.out_pred_taken = w_head.pred_taken;
  assign q.out_target     = w_head.target[XLEN-1:0];

  // record fields above XLEN carry nothing for narrow instances
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic w_unused;
    assign w_unused = ^{w_head.offset[XLEN_MAX-1:XLEN], w_head.target[XLEN_MAX-1:XLEN]};
  end
endmodule

// File: tb/tb_ifu_predecode_queue.sv
module tb_ifu_predecode_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_predecode_queue_if #(.XLEN(32), .DEPTH(DEPTH)) q ();
  ifu_predecode_queue_if #(.XLEN(32), .DEPTH(DEPTH)) q0 ();

  ifu_predecode_queue #(.XLEN(32), .DEPTH(DEPTH), .STATIC_PRED(1'b1)) u_dut (
    .clk (clk), .rst (rst), .q (q));
  ifu_predecode_queue #(.XLEN(32), .DEPTH(DEPTH), .STATIC_PRED(1'b0)) u_dut0 (
    .clk (clk), .rst (rst), .q (q0));

  // second instance sees exactly the same stimulus
  assign q0.flush     = q.flush;
  assign q0.in_valid  = q.in_valid;
  assign q0.in_instr  = q.in_instr;
  assign q0.in_pc     = q.in_pc;
  assign q0.out_ready = q.out_ready;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } word_t;

  typedef struct {
    bit          bxx, jal, jalr, pt;
    logic [31:0] off, tgt;
  } exp_t;

  word_t mq[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  function automatic exp_t ref_pd(logic [31:0] i, logic [31:0] pc, bit sp);
    exp_t e;
    int   off;
    e   = '{default: 0};
    off = 0;
    case (i[6:0])
      7'h63: begin e.bxx  = 1; off = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
      7'h6F: begin e.jal  = 1; off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
      7'h67: begin e.jalr = 1; off = $signed(i[31:20]); end
      default: ;
    endcase
    e.off = off;
    e.pt  = e.jal || (e.bxx && sp && off < 0);
    e.tgt = (e.bxx || e.jal) ? pc + off : 32'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit zero_head);
    exp_t e, e0;
    chk("count",     q.count,     mq.size());
    chk("out_valid", q.out_valid, mq.size() != 0);
    chk("in_ready",  q.in_ready,  mq.size() != DEPTH);
    chk("count_sp0", q0.count,    mq.size());
    if (mq.size() != 0) begin
      e  = ref_pd(mq[0].instr, mq[0].pc, 1'b1);
      e0 = ref_pd(mq[0].instr, mq[0].pc, 1'b0);
      chk("out_instr",  q.out_instr,      mq[0].instr);
      chk("out_pc",     q.out_pc,         mq[0].pc);
      chk("out_bxx",    q.out_bxx,        e.bxx);
      chk("out_jal",    q.out_jal,        e.jal);
      chk("out_jalr",   q.out_jalr,       e.jalr);
      chk("out_offset", q.out_offset,     e.off);
      chk("out_target", q.out_target,     e.tgt);
      chk("out_pred",   q.out_pred_taken, e.pt);
      chk("pred_sp0",   q0.out_pred_taken, e0.pt);
    end
    if (zero_head) begin
      chk("rst_instr",  q.out_instr,  0);
      chk("rst_pc",     q.out_pc,     0);
      chk("rst_flags",  {q.out_bxx, q.out_jal, q.out_jalr, q.out_pred_taken}, 0);
      chk("rst_offset", q.out_offset, 0);
      chk("rst_target", q.out_target, 0);
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, check half a cycle later
  task automatic cyc(input bit r, input bit fl, input bit v, input logic [31:0] ins,
                     input logic [31:0] pc, input bit ordy);
    bit pu, po;
    rst = r; q.flush = fl; q.in_valid = v; q.in_instr = ins; q.in_pc = pc; q.out_ready = ordy;
    @(posedge clk);
    if (r || fl) mq.delete();
    else begin
      pu = v && (mq.size() < DEPTH);
      po = ordy && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back('{instr: ins, pc: pc});
    end
    @(negedge clk);
    check_all(r);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 3))
      0: i[6:0] = 7'h63;
      1: i[6:0] = 7'h6F;
      2: i[6:0] = 7'h67;
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    q.flush = 0; q.in_valid = 0; q.in_instr = 0; q.in_pc = 0; q.out_ready = 0;
    @(negedge clk);
    // reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // backward beq at 0x100
    cyc(0, 0, 1, 32'hFE000EE3, 32'h100, 0);
    chk("beq_bxx",    q.out_bxx,         1);
    chk("beq_offset", q.out_offset,      32'hFFFFFFFC);
    chk("beq_pred",   q.out_pred_taken,  1);
    chk("beq_target", q.out_target,      32'h0FC);
    chk("beq_sp0",    q0.out_pred_taken, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // jal +8 wrapping past the top of the address space
    cyc(0, 0, 1, 32'h008000EF, 32'hFFFFFFFC, 0);
    chk("jal_flag",   q.out_jal,        1);
    chk("jal_pred",   q.out_pred_taken, 1);
    chk("jal_target", q.out_target,     32'h4);
    cyc(0, 0, 0, 0, 0, 1);

    // five offered with consumer stalled, then drain in order
    for (int k = 1; k <= 5; k++) cyc(0, 0, 1, rand_instr(), 32'h1000 + 4 * k, 0);
    chk("full_count", q.count,    4);
    chk("full_ready", q.in_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", q.out_pc, 32'h1000 + 4 * k);
      cyc(0, 0, 0, 0, 0, 1);
    end

    // full + pop + push offered: pop only, then refill next cycle
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, rand_instr(), 32'h2000 + 4 * k, 0);
    cyc(0, 0, 1, rand_instr(), 32'h2100, 1);
    chk("fullpop_count", q.count, 3);
    cyc(0, 0, 1, rand_instr(), 32'h2104, 0);
    chk("refill_count", q.count, 4);

    // flush at count 3 drops the offered word
    cyc(0, 0, 0, 0, 0, 1);
    chk("pre_flush_count", q.count, 3);
    cyc(0, 1, 1, 32'h0040006F, 32'hDEAD0000, 0);
    chk("flush_count", q.count,     0);
    chk("flush_valid", q.out_valid, 0);
    cyc(0, 0, 1, 32'h00000013, 32'h3000, 0);
    chk("post_flush_pc", q.out_pc, 32'h3000);
    cyc(0, 0, 0, 0, 0, 1);

    // streaming push/pop with random words, reset mid-stream
    for (int k = 0; k < 64; k++)
      cyc(k == 32, 0, 1, rand_instr(), $urandom & 32'hFFFFFFFC, 1);
    cyc(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
